// File: rtl/bram_word_arbiter.sv
// Round-robin arbiter that splits 32-bit word accesses into two byte-pair BRAM beats.
// Optional MISALIGN_CHECK_EN: misaligned accesses complete immediately with an error flag.
module bram_word_arbiter #(
  parameter int BRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_req,
  input  logic               r0_we,
  input  logic [31:0]        r0_addr,
  input  logic [31:0]        r0_wdata,
  input  logic [3:0]         r0_be,
  output logic               r0_ack,
  output logic               r0_err,
  output logic [31:0]        r0_rdata,
  input  logic               r1_req,
  input  logic               r1_we,
  input  logic [31:0]        r1_addr,
  input  logic [31:0]        r1_wdata,
  input  logic [3:0]         r1_be,
  output logic               r1_ack,
  output logic               r1_err,
  output logic [31:0]        r1_rdata,
  output logic               busy,
  output logic               en,
  output logic               we_a,
  output logic               we_b,
  output logic [BRAM_AW-1:0] addr_a,
  output logic [BRAM_AW-1:0] addr_b,
  output logic [7:0]         data_a,
  output logic [7:0]         data_b,
  input  logic [7:0]         recv_data_a,
  input  logic [7:0]         recv_data_b
);

  typedef enum logic [2:0] {S_IDLE, S_A0, S_A1, S_A2, S_ACK} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic               r_id;
  logic               r_we;
  logic [BRAM_AW-3:0] r_word;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_rd_data;

  logic               w_grant_valid;
  logic               w_grant_id;
  logic               w_misalign;
  logic [BRAM_AW-3:0] w_sel_word;
  logic               w_unused_addr;

  assign w_grant_valid = r0_req | r1_req;
  // On a tie the requester that did not win last time is served.
  assign w_grant_id    = (r0_req & r1_req) ? ~r_last_grant : r1_req;
  assign w_sel_word    = w_grant_id ? r1_addr[BRAM_AW-1:2] : r0_addr[BRAM_AW-1:2];
  assign w_unused_addr = ^{r0_addr[31:BRAM_AW], r1_addr[31:BRAM_AW], r0_addr[1:0], r1_addr[1:0]};

`ifdef MISALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = w_grant_id ? (|r1_addr[1:0]) : (|r0_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_valid) w_next = w_misalign ? S_ACK : S_A0;
      S_A0:    w_next = S_A1;
      S_A1:    w_next = r_we ? S_ACK : S_A2;
      S_A2:    w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_word       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_rd_data    <= '0;
`ifdef MISALIGN_CHECK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE && w_grant_valid) begin
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_we         <= w_grant_id ? r1_we    : r0_we;
        r_wdata      <= w_grant_id ? r1_wdata : r0_wdata;
        r_be         <= w_grant_id ? r1_be    : r0_be;
        r_word       <= w_sel_word;
`ifdef MISALIGN_CHECK_EN
        r_err        <= w_misalign;
`endif
      end
      // BRAM read data lags the address by one cycle, so each beat lands one state later.
      if (r_state == S_A1 && !r_we) r_rd_data[15:0]  <= {recv_data_b, recv_data_a};
      if (r_state == S_A2)          r_rd_data[31:16] <= {recv_data_b, recv_data_a};
    end
  end

  always_comb begin
    busy   = (r_state != S_IDLE);
    en     = 1'b0;
    we_a   = 1'b0;
    we_b   = 1'b0;
    addr_a = '0;
    addr_b = '0;
    data_a = '0;
    data_b = '0;
    r0_ack = 1'b0;
    r1_ack = 1'b0;
    r0_err = 1'b0;
    r1_err = 1'b0;
    case (r_state)
      S_A0: begin
        en     = 1'b1;
        addr_a = {r_word, 2'b00};
        addr_b = {r_word, 2'b01};
        data_a = r_wdata[7:0];
        data_b = r_wdata[15:8];
        we_a   = r_we & r_be[0];
        we_b   = r_we & r_be[1];
      end
      S_A1: begin
        en     = 1'b1;
        addr_a = {r_word, 2'b10};
        addr_b = {r_word, 2'b11};
        data_a = r_wdata[23:16];
        data_b = r_wdata[31:24];
        we_a   = r_we & r_be[2];
        we_b   = r_we & r_be[3];
      end
      S_ACK: begin
        r0_ack = ~r_id;
        r1_ack = r_id;
`ifdef MISALIGN_CHECK_EN
        r0_err = ~r_id & r_err;
        r1_err = r_id & r_err;
`endif
      end
      default: ;
    endcase
  end

  assign r0_rdata = r_rd_data;
  assign r1_rdata = r_rd_data;

endmodule
